// File: rtl/ads1292_uart_packer_if.sv
// UART transmit word channel: 40-bit frame with a valid/ready handshake.
interface ads1292_uart_packer_if;
  logic [39:0] data;
  logic        valid;
  logic        ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ads1292_uart_packer.sv
// Validates ADS1292 RDATAC samples, queues them, and emits each one as a CH1/CH2
// pair of tagged 40-bit UART frames carrying a per-sample sequence number.
module ads1292_uart_packer #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] HDR_CH1    = 8'hC1,
  parameter logic [7:0] HDR_CH2    = 8'hC2,
  parameter int         DECIM      = 1
) (
  input  logic                        i_CLK,
  input  logic                        i_RST,
  input  logic                        i_ENABLE,
  input  logic [71:0]                 i_ADS1292_DATA_OUT,
  input  logic                        i_ADS1292_DATA_READY,
  ads1292_uart_packer_if.master       uart,
  output logic [4:0]                  o_LOFF_STAT,
  output logic [7:0]                  o_STATUS_ERR_CNT,
  output logic [7:0]                  o_DROP_CNT,
  output logic [$clog2(FIFO_DEPTH):0] o_FIFO_LEVEL
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  DEC_LAST = 8'(DECIM - 1);

  typedef enum logic [1:0] {IDLE, SEND1, SEND2} state_t;

  state_t        state, state_d;
  logic          rdy_q;
  logic [7:0]    seq, dec_cnt;
  logic [55:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic [7:0]    hold_seq;
  logic [23:0]   hold_ch2;
  logic [39:0]   tx_data, data_d;
  logic          tx_valid, valid_d;
  logic          capture, status_ok, take, enq_req, enq, drop, pop;
  logic [55:0]   head;

  assign capture   = i_ADS1292_DATA_READY & ~rdy_q & i_ENABLE;
  assign status_ok = i_ADS1292_DATA_OUT[71:68] == 4'b1100;
  assign take      = capture & status_ok;
  assign enq_req   = take & (dec_cnt == 8'd0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign enq       = enq_req & ((level != FULL_LVL) | pop);
  assign drop      = enq_req & ~enq;
  assign head      = mem[rd_ptr];

  assign uart.data    = tx_data;
  assign uart.valid   = tx_valid;
  assign o_FIFO_LEVEL = level;

  always_ff @(posedge i_CLK) begin
    if (enq) mem[wr_ptr] <= {seq, i_ADS1292_DATA_OUT[47:0]};
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      rdy_q            <= 1'b0;
      seq              <= '0;
      dec_cnt          <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      level            <= '0;
      o_LOFF_STAT      <= '0;
      o_STATUS_ERR_CNT <= '0;
      o_DROP_CNT       <= '0;
    end else begin
      rdy_q <= i_ADS1292_DATA_READY;
      if (capture && !status_ok && o_STATUS_ERR_CNT != 8'hFF)
        o_STATUS_ERR_CNT <= o_STATUS_ERR_CNT + 8'd1;
      if (take) begin
        o_LOFF_STAT <= i_ADS1292_DATA_OUT[67:63];
        dec_cnt     <= (dec_cnt == DEC_LAST) ? 8'd0 : dec_cnt + 8'd1;
      end
      if (drop && o_DROP_CNT != 8'hFF) o_DROP_CNT <= o_DROP_CNT + 8'd1;
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
        seq    <= seq + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      hold_seq <= '0;
      hold_ch2 <= '0;
    end else begin
      state    <= state_d;
      tx_data  <= data_d;
      tx_valid <= valid_d;
      if (pop) begin
        hold_seq <= head[55:48];
        hold_ch2 <= head[23:0];
      end
    end
  end

  always_comb begin
    state_d = state;
    data_d  = tx_data;
    valid_d = tx_valid;
    pop     = 1'b0;
    case (state)
      IDLE: if (level != '0) begin
        pop     = 1'b1;
        data_d  = {HDR_CH1, head[55:48], head[47:24]};
        valid_d = 1'b1;
        state_d = SEND1;
      end
      SEND1: if (tx_valid && uart.ready) begin
        data_d  = {HDR_CH2, hold_seq, hold_ch2};
        state_d = SEND2;
      end
      SEND2: if (tx_valid && uart.ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ads1292_uart_packer.sv
// Directed scoreboard bench: expected frames are queued by stimulus, popped by monitors.
module tb_ads1292_uart_packer;
  logic        clk = 0, rst = 0, en = 0, en2 = 0, ads_rdy = 0;
  logic [71:0] ads_data = '0;
  logic [4:0]  loff, loff2;
  logic [7:0]  err, drop, err2, drop2;
  logic [2:0]  lvl, lvl2;
  int          n_vec = 0, n_err = 0;
  logic [39:0] exp_q [$];
  logic [39:0] exp2_q [$];

  ads1292_uart_packer_if bus ();
  ads1292_uart_packer_if bus2 ();

  ads1292_uart_packer #(.FIFO_DEPTH(4), .DECIM(1)) dut (
    .i_CLK(clk), .i_RST(rst), .i_ENABLE(en), .i_ADS1292_DATA_OUT(ads_data),
    .i_ADS1292_DATA_READY(ads_rdy), .uart(bus.master), .o_LOFF_STAT(loff),
    .o_STATUS_ERR_CNT(err), .o_DROP_CNT(drop), .o_FIFO_LEVEL(lvl));

  ads1292_uart_packer #(.FIFO_DEPTH(4), .DECIM(3)) dut2 (
    .i_CLK(clk), .i_RST(rst), .i_ENABLE(en2), .i_ADS1292_DATA_OUT(ads_data),
    .i_ADS1292_DATA_READY(ads_rdy), .uart(bus2.master), .o_LOFF_STAT(loff2),
    .o_STATUS_ERR_CNT(err2), .o_DROP_CNT(drop2), .o_FIFO_LEVEL(lvl2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [71:0] d, input int hi, input int lo);
    ads_data = d; ads_rdy = 1;
    repeat (hi) tick();
    ads_rdy = 0;
    repeat (lo) tick();
  endtask

  task automatic push_pair(input logic [7:0] s, input logic [23:0] c1, input logic [23:0] c2);
    exp_q.push_back({8'hC1, s, c1});
    exp_q.push_back({8'hC2, s, c2});
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < 400) begin tick(); n++; end
    chk(name, 64'(exp_q.size() + exp2_q.size()), 64'd0);
  endtask

  // Monitors: a transfer is valid & ready at the coming edge, sampled mid-cycle.
  always @(negedge clk) if (bus.valid && bus.ready) begin
    if (exp_q.size() == 0) chk("unexpected_frame", {24'd0, bus.data}, 64'hDEAD);
    else chk("frame", {24'd0, bus.data}, {24'd0, exp_q.pop_front()});
  end

  always @(negedge clk) if (bus2.valid && bus2.ready) begin
    if (exp2_q.size() == 0) chk("unexpected_frame_decim", {24'd0, bus2.data}, 64'hDEAD);
    else chk("frame_decim", {24'd0, bus2.data}, {24'd0, exp2_q.pop_front()});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    logic [39:0] held;
    int n;
    bus.ready = 1; bus2.ready = 1;
    tick();
    do_reset();
    chk("rst_valid", 64'(bus.valid), 0);
    chk("rst_data", 64'(bus.data), 0);
    chk("rst_cnts", {err, drop, 3'(lvl), loff}, 0);
    en = 1;

    // single sample, latency, flag held two cycles gives one capture
    push_pair(8'd0, 24'h123456, 24'hABCDEF);
    ads_data = {24'hC00000, 24'h123456, 24'hABCDEF}; ads_rdy = 1;
    tick(); chk("lat_n1_valid", 64'(bus.valid), 0);
    tick(); chk("lat_n2_ch1", {23'd0, bus.valid, bus.data}, {23'd0, 1'b1, 40'hC100123456});
    ads_rdy = 0;
    tick(); chk("lat_n3_ch2", {23'd0, bus.valid, bus.data}, {23'd0, 1'b1, 40'hC200ABCDEF});
    tick(); chk("lat_n4_idle", 64'(bus.valid), 0);
    drain("drain_single");

    // backpressure on CH1
    bus.ready = 0;
    push_pair(8'd1, 24'h111111, 24'h222222);
    pulse({24'hC00000, 24'h111111, 24'h222222}, 1, 1);
    n = 0;
    while (!bus.valid && n < 20) begin tick(); n++; end
    held = bus.data;
    chk("bp_first", 64'(held), 64'hC101111111);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_stable", {23'd0, bus.valid, bus.data}, {23'd0, 1'b1, held});
    end
    bus.ready = 1;
    tick(); chk("bp_ch2", 64'(bus.data), 64'hC201222222);
    drain("drain_bp");

    // overflow: hold + 4 queued, sixth sample dropped
    do_reset();
    bus.ready = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) push_pair(8'(i), 24'h100000 + 24'(i), 24'h200000 + 24'(i));
      pulse({24'hC00000, 24'h100000 + 24'(i), 24'h200000 + 24'(i)}, 1, 1);
    end
    chk("ovf_drop", 64'(drop), 1);
    chk("ovf_level", 64'(lvl), 4);
    bus.ready = 1;
    drain("drain_ovf");
    push_pair(8'd5, 24'h100006, 24'h200006);
    pulse({24'hC00000, 24'h100006, 24'h200006}, 1, 3);
    drain("drain_after_drop");

    // lead-off capture, then bad status samples
    push_pair(8'd6, 24'h000777, 24'h000888);
    pulse({24'hC50000, 24'h000777, 24'h000888}, 1, 3);
    drain("drain_loff");
    chk("loff_stat", 64'(loff), 5'h0A);
    pulse({24'h800000, 24'h999999, 24'h999999}, 1, 4);
    chk("err_one", 64'(err), 1);
    chk("loff_keep", 64'(loff), 5'h0A);
    for (int i = 0; i < 299; i++) pulse({24'h800000, 48'd0}, 1, 1);
    chk("err_sat", 64'(err), 255);
    chk("no_frames_bad", 64'(exp_q.size()), 0);

    // sequence wrap over 257 samples
    do_reset();
    for (int i = 0; i < 257; i++) begin
      push_pair(8'(i), 24'(i), ~24'(i));
      pulse({24'hC00000, 24'(i), ~24'(i)}, 1, 3);
    end
    drain("drain_wrap");
    chk("wrap_drop", 64'(drop), 0);

    // decimation by 3 on the second instance; first instance disabled
    en = 0; en2 = 1;
    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 0) begin
        exp2_q.push_back({8'hC1, 8'(i / 3), 24'h300000 + 24'(i)});
        exp2_q.push_back({8'hC2, 8'(i / 3), 24'h400000 + 24'(i)});
      end
      pulse({24'hC00000, 24'h300000 + 24'(i), 24'h400000 + 24'(i)}, 1, 3);
    end
    drain("drain_decim");
    chk("disabled_level", 64'(lvl), 0);
    en = 1; en2 = 0;

    // reset while in SEND2 with two samples queued
    pulse({24'h800000, 48'd0}, 1, 1);
    bus.ready = 0;
    exp_q.push_back({8'hC1, 8'd1, 24'h500000});
    for (int i = 0; i < 3; i++) pulse({24'hC50000, 24'h500000 + 24'(i), 24'h600000 + 24'(i)}, 1, 1);
    chk("r6_level", 64'(lvl), 2);
    bus.ready = 1; tick(); bus.ready = 0;
    chk("r6_send2", {23'd0, bus.valid, bus.data}, {23'd0, 1'b1, 40'hC201600000});
    rst = 1; tick(); rst = 0;
    chk("r6_valid", 64'(bus.valid), 0);
    chk("r6_cnts", {err, drop, 3'(lvl), loff}, 0);
    bus.ready = 1;
    push_pair(8'd0, 24'h700000, 24'h800000);
    pulse({24'hC00000, 24'h700000, 24'h800000}, 1, 3);
    drain("drain_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
